// File: rtl/generic_2clk_fifo_wr_arb_pkg.sv
// Shared types for the FIFO write-port arbiter: FSM state encoding
// and width helpers used to size requester index signals.
package generic_2clk_fifo_wr_arb_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } arb_state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = 1; v < n; v = v * 2) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Index width for n requesters, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/generic_2clk_fifo_wr_arb_rr_pick.sv
// generic_rr_pick: combinational round-robin priority picker.
// Ports: i_req request vector, i_ptr highest-priority index,
//        o_gnt one-hot grant, o_idx granted index, o_any any granted.
module generic_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    // Scan from i_ptr upward with wrap; first set request wins.
    always_comb begin
        int j;
        j     = 0;
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[j]) begin
                o_any    = 1'b1;
                o_gnt[j] = 1'b1;
                o_idx    = IW'(j);
            end
        end
    end

endmodule

// File: rtl/generic_2clk_fifo_wr_arb.sv
// Packet-aware round-robin arbiter sharing one dual-clock FIFO write port.
// Ports: clk/reset (sync, active-high); req_valid/req_last/req_data from
//        requesters, req_gnt one-hot accept; fifo_wr_op/data/mask to FIFO,
//        fifo_wr_entry_used/fifo_wr_full_err from FIFO; owner, busy, ovf_err.
module generic_2clk_fifo_wr_arb
    import generic_2clk_fifo_wr_arb_pkg::*;
#(
    parameter  int NUM_REQ        = 4,
    parameter  int DAT_WIDTH      = 35,
    parameter  int PTR_WIDTH      = 3,
    parameter  int NUM_OF_ENTRIES = 8,
    localparam int OW             = idx_w(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    input  logic [NUM_REQ*DAT_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]           req_gnt,
    output logic                         fifo_wr_op,
    output logic [DAT_WIDTH-1:0]         fifo_wr_data,
    output logic [DAT_WIDTH-1:0]         fifo_wr_mask,
    input  logic [PTR_WIDTH:0]           fifo_wr_entry_used,
    input  logic                         fifo_wr_full_err,
    output logic [OW-1:0]                owner,
    output logic                         busy,
    output logic                         ovf_err
);

    arb_state_e             r_state;
    arb_state_e             w_state_nxt;
    logic [OW-1:0]          r_rr_ptr;
    logic [OW-1:0]          w_rr_ptr_nxt;
    logic [OW-1:0]          r_owner;
    logic [OW-1:0]          w_owner_nxt;
    logic                   r_wr_op;
    logic [DAT_WIDTH-1:0]   r_wr_data;
    logic                   r_ovf;

    logic [PTR_WIDTH+1:0]   w_used_sum;
    logic                   w_space;
    logic [NUM_REQ-1:0]     w_pick_req;
    logic [NUM_REQ-1:0]     w_pick_gnt;
    logic [OW-1:0]          w_pick_idx;
    logic                   w_pick_any;
    logic [NUM_REQ-1:0]     w_gnt;
    logic [OW-1:0]          w_sel_idx;
    logic                   w_xfer;
    logic [DAT_WIDTH-1:0]   w_sel_data;

    function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] v);
        return (v == OW'(NUM_REQ - 1)) ? '0 : v + OW'(1);
    endfunction

    // The beat registered last cycle is not yet counted by the FIFO.
    assign w_used_sum = {1'b0, fifo_wr_entry_used}
                      + {{(PTR_WIDTH+1){1'b0}}, r_wr_op};
    assign w_space    = w_used_sum < (PTR_WIDTH+2)'(NUM_OF_ENTRIES);
    assign w_pick_req = req_valid & {NUM_REQ{w_space & ~reset}};

    generic_rr_pick #(
        .N  (NUM_REQ),
        .IW (OW)
    ) u_pick (
        .i_req (w_pick_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_pick_gnt),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_rr_ptr_nxt = r_rr_ptr;
        w_owner_nxt  = r_owner;
        w_gnt        = '0;
        w_sel_idx    = r_owner;
        unique case (r_state)
            ST_IDLE: begin
                w_gnt     = w_pick_gnt;
                w_sel_idx = w_pick_idx;
                if (w_pick_any) begin
                    if (req_last[w_pick_idx]) begin
                        w_rr_ptr_nxt = wrap_inc(w_pick_idx);
                    end else begin
                        w_state_nxt = ST_LOCK;
                        w_owner_nxt = w_pick_idx;
                    end
                end
            end
            ST_LOCK: begin
                // Only the owner may move; a dropped valid is a bubble.
                if (req_valid[r_owner] && w_space && !reset) begin
                    w_gnt[r_owner] = 1'b1;
                    if (req_last[r_owner]) begin
                        w_state_nxt  = ST_IDLE;
                        w_rr_ptr_nxt = wrap_inc(r_owner);
                    end
                end
            end
            default: ;
        endcase
    end

    assign w_xfer     = |w_gnt;
    assign w_sel_data = req_data[w_sel_idx*DAT_WIDTH +: DAT_WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_rr_ptr  <= '0;
            r_owner   <= '0;
            r_wr_op   <= 1'b0;
            r_wr_data <= '0;
            r_ovf     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rr_ptr <= w_rr_ptr_nxt;
            r_owner  <= w_owner_nxt;
            r_wr_op  <= w_xfer;
            if (w_xfer) begin
                r_wr_data <= w_sel_data;
            end
            if (fifo_wr_full_err) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign req_gnt      = w_gnt;
    assign fifo_wr_op   = r_wr_op;
    assign fifo_wr_data = r_wr_data;
    assign fifo_wr_mask = '1;
    assign owner        = r_owner;
    assign busy         = (r_state == ST_LOCK);
    assign ovf_err      = r_ovf;

endmodule

// File: doc/generic_2clk_fifo_wr_arb.md
# generic_2clk_fifo_wr_arb

Packet-aware round-robin arbiter that shares the write port of a generic dual-clock FIFO envelope among several requesters in the write clock domain. It accepts one data beat per cycle from the winning requester and drives a registered write strobe and data into the FIFO. It throttles on the FIFO's write-side occupancy so the FIFO never overflows. Once a requester wins, it owns the port until it presents its last beat, so packets are never interleaved in the FIFO.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DAT_WIDTH, 35, FIFO data width
- PTR_WIDTH, 3, FIFO address width; occupancy is PTR_WIDTH+1 bits
- NUM_OF_ENTRIES, 8, FIFO depth (≤ 2^PTR_WIDTH)

Ports:
- clk  in  1  write-domain clock, the same clock as the FIFO write port
- reset  in  1  synchronous, active-high
- req_valid  in  NUM_REQ  per-requester beat valid
- req_last  in  NUM_REQ  marks the requester's final beat of a packet
- req_data  in  NUM_REQ*DAT_WIDTH  requester i occupies bits [i*DAT_WIDTH +: DAT_WIDTH]
- req_gnt  out  NUM_REQ  one-hot beat-accept strobe, combinational
- fifo_wr_op  out  1  registered write strobe to the FIFO
- fifo_wr_data  out  DAT_WIDTH  registered write data
- fifo_wr_mask  out  DAT_WIDTH  constant all-ones
- fifo_wr_entry_used  in  PTR_WIDTH+1  FIFO write-side occupancy
- fifo_wr_full_err  in  1  FIFO overflow indication
- owner  out  log2(NUM_REQ)  current or last owner index
- busy  out  1  high while in LOCK
- ovf_err  out  1  sticky overflow flag

## Operation
- **States:** IDLE and LOCK. The round-robin pointer rr_ptr indicates the highest-priority requester.
- **space:** high when fifo_wr_entry_used + fifo_wr_op < NUM_OF_ENTRIES. Compute the sum at PTR_WIDTH+2 bits. The fifo_wr_op term accounts for the one beat already in flight.
- **IDLE:**
  - If space is high, grant the first requester with req_valid set, searching from rr_ptr upward with wrap.
  - If the granted beat has req_last=1, stay in IDLE and set rr_ptr = winner+1 mod NUM_REQ.
  - If the granted beat has req_last=0, go to LOCK and set owner = winner.
- **LOCK:**
  - Only the owner can be granted, when req_valid[owner]=1 and space=1. All other requesters stall.
  - When a beat with req_last=1 is granted, return to IDLE and set rr_ptr = owner+1 mod NUM_REQ.
  - If the owner drops req_valid, the state stays in LOCK and a bubble is inserted. There is no timeout.
- **Handshake:** a transfer occurs when req_valid[i] and req_gnt[i] are both high. A requester holds its valid, data and last stable until it is granted. A grant never asserts without req_valid.
- **Write path:** on any transfer, fifo_wr_op=1 and fifo_wr_data=the granted data on the next cycle. Otherwise fifo_wr_op=0 and fifo_wr_data holds its previous value.
- **ovf_err:** set on any cycle where fifo_wr_full_err=1. It is cleared only by reset.

## Timing
- **Reset values:** fifo_wr_op=0, fifo_wr_data=0, req_gnt=0, owner=0, rr_ptr=0, busy=0, ovf_err=0, state IDLE.
- **Latency:** the grant is in the same cycle as the request. fifo_wr_op follows one cycle later. Peak throughput is one beat per cycle.
- **Full boundary:**
  - With entry_used = NUM_OF_ENTRIES-1 and fifo_wr_op=1, no grant is issued.
  - With entry_used = NUM_OF_ENTRIES-1 and fifo_wr_op=0, exactly one grant is issued.
- **Single-beat packets:** a beat with req_last=1 accepted in IDLE never enters LOCK.
- **Simultaneous requests:** all requesters valid in IDLE are served in rotation one packet each: rr_ptr, rr_ptr+1, and so on.
- **rr_ptr wrap:** the pointer wraps from NUM_REQ-1 to 0.
- **Reset mid-packet:** reset forces IDLE immediately. The partial packet already in the FIFO is not repaired; upstream handles recovery.
- **Reset and fifo_wr_full_err together:** reset wins and ovf_err=0.

## Structure
- Shared package holds the state encoding (IDLE=1'b0, LOCK=1'b1) and a clog2 function for owner width.
- One sub-module, generic_rr_pick: a combinational round-robin priority picker with inputs req[NUM_REQ] and ptr and outputs a one-hot grant and an index. It is reusable by other arbiters.

## Test plan
- Single requester 0 sends a 3-beat packet D0..D2 into an empty FIFO → req_gnt[0] on 3 consecutive cycles, fifo_wr_op high for cycles 1..3 with D0..D2, state returns to IDLE, rr_ptr=1.
- Requesters 1 and 3 both send 2-beat packets while rr_ptr=2 → requester 3 is served fully first, then requester 1, with no interleaving; final rr_ptr=2.
- Back-pressure: a 10-beat packet into an 8-entry FIFO that is not drained → exactly 8 grants, then req_gnt=0 while entry_used=8. After the read side pops 2 → 2 more grants.
- Owner stall: owner drops valid for 4 cycles mid-packet while requester 2 is valid → no grant to requester 2 until the owner's last beat is granted.
- Reset asserted in LOCK after 1 of 3 beats → the cycle after reset: IDLE, busy=0, fifo_wr_op=0, rr_ptr=0.
- Force fifo_wr_full_err for 1 cycle → ovf_err=1 and it stays 1 until reset.
